mul_div_unit: RTL and testbench

Iterative multi-cycle multiply/divide unit for the MIPS-style datapath. Sits directly downstream of the register file and consumes its two read ports (RD1 → rs_i, RD2 → rt_i). Executes MULT/MULTU/DIV/DIVU into private HI/LO registers and supports MTHI/MTLO writes. Control stalls the pipeline on busy_o; MFHI/MFLO read hi_o/lo_o.

---
 rtl/mul_div_unit_if.sv | 27 ++
 rtl/mul_div_unit.sv | 141 ++++++++++++++
 tb/tb_mul_div_unit.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/mul_div_unit_if.sv
// Handshake and operand bus between the register file/control and the
// iterative multiply/divide unit.
interface mul_div_unit_if #(
    parameter int XLEN = 32
);
    logic            start_i;
    logic [1:0]      op_i;
    logic [XLEN-1:0] rs_i;
    logic [XLEN-1:0] rt_i;
    logic            mthi_i;
    logic            mtlo_i;
    logic            busy_o;
    logic            done_o;
    logic [XLEN-1:0] hi_o;
    logic [XLEN-1:0] lo_o;
    logic            div_by_zero_o;

    modport master (
        output start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i,
        input  busy_o, done_o, hi_o, lo_o, div_by_zero_o
    );

    modport slave (
        input  start_i, op_i, rs_i, rt_i, mthi_i, mtlo_i,
        output busy_o, done_o, hi_o, lo_o, div_by_zero_o
    );
endinterface

// File: rtl/mul_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU unit with private HI/LO registers.
// One shift-add or restoring-divide step per cycle, then a sign fix-up.
module mul_div_unit #(
    parameter int XLEN = 32
) (
    input  logic          clk_50,
    input  logic          rst_i,
    mul_div_unit_if.slave bus
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic              r_is_div;
    logic              r_neg_q;
    logic              r_neg_r;
    logic              r_dz;
    logic [XLEN-1:0]   r_b;
    logic [2*XLEN-1:0] r_acc;
    logic [XLEN-1:0]   r_hi;
    logic [XLEN-1:0]   r_lo;
    logic              r_busy;
    logic              r_done;
    logic              r_dz_o;

    logic              w_dz;
    logic              w_sgn;
    logic              w_sa;
    logic              w_sb;
    logic [XLEN-1:0]   w_ma;
    logic [XLEN-1:0]   w_mb;
    logic [XLEN:0]     w_madd;
    logic [2*XLEN-1:0] w_mstep;
    logic [XLEN:0]     w_rsh;
    logic [XLEN:0]     w_dif;
    logic [2*XLEN-1:0] w_dstep;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_quo;
    logic [XLEN-1:0]   w_rem;

    // Operand conditioning: a zero divisor runs unsigned so the
    // restoring loop naturally yields HI=rs, LO=all ones.
    always_comb begin
        w_dz  = bus.op_i[1] & (bus.rt_i == '0);
        w_sgn = bus.op_i[0] & ~w_dz;
        w_sa  = w_sgn & bus.rs_i[XLEN-1];
        w_sb  = w_sgn & bus.rt_i[XLEN-1];
        w_ma  = w_sa ? -bus.rs_i : bus.rs_i;
        w_mb  = w_sb ? -bus.rt_i : bus.rt_i;
    end

    // One iteration step for multiply and divide, plus final sign fix-up.
    always_comb begin
        w_madd  = {1'b0, r_acc[2*XLEN-1:XLEN]} + {1'b0, r_b};
        w_mstep = r_acc[0] ? {w_madd, r_acc[XLEN-1:1]}
                           : {1'b0, r_acc[2*XLEN-1:1]};
        w_rsh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
        w_dif   = w_rsh - {1'b0, r_b};
        w_dstep = w_dif[XLEN]
                ? {w_rsh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                : {w_dif[XLEN-1:0], r_acc[XLEN-2:0], 1'b1};
        w_prod  = r_neg_q ? -r_acc : r_acc;
        w_quo   = r_neg_q ? -r_acc[XLEN-1:0] : r_acc[XLEN-1:0];
        w_rem   = r_neg_r ? -r_acc[2*XLEN-1:XLEN]
                          : r_acc[2*XLEN-1:XLEN];
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk_50 or posedge rst_i) begin
        if (rst_i) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_is_div <= 1'b0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            r_dz     <= 1'b0;
            r_b      <= '0;
            r_acc    <= '0;
            r_hi     <= '0;
            r_lo     <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_dz_o   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            r_dz_o <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_state  <= S_CALC;
                        r_busy   <= 1'b1;
                        r_cnt    <= '0;
                        r_is_div <= bus.op_i[1];
                        r_neg_q  <= w_sa ^ w_sb;
                        r_neg_r  <= w_sa;
                        r_dz     <= w_dz;
                        r_b      <= w_mb;
                        r_acc    <= {{XLEN{1'b0}}, w_ma};
                    end else begin
                        if (bus.mthi_i) r_hi <= bus.rs_i;
                        if (bus.mtlo_i) r_lo <= bus.rs_i;
                    end
                end
                S_CALC: begin
                    r_acc <= r_is_div ? w_dstep : w_mstep;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(XLEN - 1)) r_state <= S_FIX;
                end
                S_FIX: begin
                    if (r_is_div) begin
                        r_hi <= w_rem;
                        r_lo <= w_quo;
                    end else begin
                        r_hi <= w_prod[2*XLEN-1:XLEN];
                        r_lo <= w_prod[XLEN-1:0];
                    end
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                    r_dz_o  <= r_dz;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy_o        = r_busy;
    assign bus.done_o        = r_done;
    assign bus.hi_o          = r_hi;
    assign bus.lo_o          = r_lo;
    assign bus.div_by_zero_o = r_dz_o;
endmodule

// File: tb/tb_mul_div_unit.sv
// Scoreboard bench for mul_div_unit: expected HI/LO/flag are queued
// at launch and compared when done_o is seen.
module tb_mul_div_unit;
    logic clk_50 = 1'b0;
    logic rst_i;

    always #10 clk_50 = ~clk_50;

    mul_div_unit_if #(.XLEN(32)) bus ();

    mul_div_unit #(.XLEN(32)) dut (
        .clk_50 (clk_50),
        .rst_i  (rst_i),
        .bus    (bus)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
    } exp_t;

    exp_t        scb[$];
    int          n_vec = 0;
    int          n_err = 0;
    logic [31:0] pre_hi;
    logic [31:0] pre_lo;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %08h want %08h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] op,
                                   input logic [31:0] a,
                                   input logic [31:0] b);
        exp_t        e;
        logic [63:0] u;
        longint      pa;
        longint      pb;
        longint      p;
        int          sa;
        int          sbv;
        e.dz = 1'b0;
        e.hi = '0;
        e.lo = '0;
        case (op)
            2'b00: begin
                u    = {32'b0, a} * {32'b0, b};
                e.hi = u[63:32];
                e.lo = u[31:0];
            end
            2'b01: begin
                pa   = longint'($signed(a));
                pb   = longint'($signed(b));
                p    = pa * pb;
                e.hi = p[63:32];
                e.lo = p[31:0];
            end
            default: begin
                if (b == 32'h0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                    e.dz = 1'b1;
                end else if (op == 2'b10) begin
                    e.lo = a / b;
                    e.hi = a % b;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.lo = 32'h8000_0000;
                    e.hi = 32'h0;
                end else begin
                    sa   = a;
                    sbv  = b;
                    e.lo = sa / sbv;
                    e.hi = sa % sbv;
                end
            end
        endcase
        return e;
    endfunction

    task automatic launch(input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic mt);
        scb.push_back(model(op, a, b));
        pre_hi      = bus.hi_o;
        pre_lo      = bus.lo_o;
        bus.start_i = 1'b1;
        bus.op_i    = op;
        bus.rs_i    = a;
        bus.rt_i    = b;
        bus.mthi_i  = mt;
        bus.mtlo_i  = mt;
        @(negedge clk_50);
        bus.start_i = 1'b0;
        bus.mthi_i  = 1'b0;
        bus.mtlo_i  = 1'b0;
    endtask

    task automatic wait_done(input logic disturb);
        int   cyc = 0;
        exp_t e;
        while (bus.busy_o === 1'b1 && cyc < 100) begin
            cyc++;
            if (cyc == 1) begin
                chk("done_clr", 32'(bus.done_o), 32'd0);
                chk("dz_low", 32'(bus.div_by_zero_o), 32'd0);
            end
            if (cyc == 16) begin
                chk("hi_hold", bus.hi_o, pre_hi);
                chk("lo_hold", bus.lo_o, pre_lo);
            end
            if (disturb) begin
                bus.start_i = (cyc <= 3);
                bus.mthi_i  = (cyc <= 3);
                bus.mtlo_i  = (cyc <= 3);
                bus.op_i    = 2'b10;
                bus.rs_i    = 32'h1234;
                bus.rt_i    = 32'h5;
            end
            @(negedge clk_50);
        end
        chk("busy_len", 32'(cyc), 32'd33);
        chk("done", 32'(bus.done_o), 32'd1);
        chk("scb_size", 32'(scb.size()), 32'd1);
        if (scb.size() > 0) begin
            e = scb.pop_front();
            chk("hi", bus.hi_o, e.hi);
            chk("lo", bus.lo_o, e.lo);
            chk("dz", 32'(bus.div_by_zero_o), 32'(e.dz));
        end
    endtask

    task automatic idle_chk();
        @(negedge clk_50);
        chk("done_pulse", 32'(bus.done_o), 32'd0);
        chk("dz_pulse", 32'(bus.div_by_zero_o), 32'd0);
    endtask

    initial begin
        logic [1:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        int          nd;
        rst_i       = 1'b1;
        bus.start_i = 1'b0;
        bus.op_i    = 2'b00;
        bus.rs_i    = '0;
        bus.rt_i    = '0;
        bus.mthi_i  = 1'b0;
        bus.mtlo_i  = 1'b0;
        repeat (2) @(negedge clk_50);
        chk("rst_busy", 32'(bus.busy_o), 32'd0);
        chk("rst_done", 32'(bus.done_o), 32'd0);
        chk("rst_hi", bus.hi_o, 32'd0);
        chk("rst_lo", bus.lo_o, 32'd0);
        chk("rst_dz", 32'(bus.div_by_zero_o), 32'd0);
        rst_i = 1'b0;
        @(negedge clk_50);

        launch(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        wait_done(1'b0);
        idle_chk();
        launch(2'b01, 32'hFFFF_FFFD, 32'd7, 1'b0);
        wait_done(1'b0);
        launch(2'b11, 32'hFFFF_FFF9, 32'd2, 1'b0);
        wait_done(1'b0);
        idle_chk();
        launch(2'b10, 32'd100, 32'd0, 1'b0);
        wait_done(1'b0);
        idle_chk();
        launch(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_done(1'b0);
        idle_chk();
        launch(2'b00, 32'h1234_5678, 32'h9ABC_DEF0, 1'b0);
        wait_done(1'b1);
        idle_chk();

        for (int i = 0; i < 8; i++) begin
            op = 2'($urandom_range(3, 0));
            a  = $urandom;
            b  = (i == 3) ? 32'h0 : ($urandom >> $urandom_range(31, 0));
            launch(op, a, b, 1'b0);
            wait_done(1'b0);
        end
        idle_chk();

        bus.mthi_i = 1'b1;
        bus.rs_i   = 32'hAAAA_0000;
        @(negedge clk_50);
        bus.mthi_i = 1'b0;
        bus.mtlo_i = 1'b1;
        bus.rs_i   = 32'h0000_5555;
        @(negedge clk_50);
        bus.mtlo_i = 1'b0;
        chk("mthi", bus.hi_o, 32'hAAAA_0000);
        chk("mtlo", bus.lo_o, 32'h0000_5555);
        bus.mthi_i = 1'b1;
        bus.mtlo_i = 1'b1;
        bus.rs_i   = 32'h0F0F_0F0F;
        @(negedge clk_50);
        bus.mthi_i = 1'b0;
        bus.mtlo_i = 1'b0;
        chk("mt_both_hi", bus.hi_o, 32'h0F0F_0F0F);
        chk("mt_both_lo", bus.lo_o, 32'h0F0F_0F0F);

        launch(2'b00, 32'd3, 32'd5, 1'b1);
        wait_done(1'b0);
        idle_chk();

        launch(2'b10, 32'd1000, 32'd7, 1'b0);
        repeat (9) @(negedge clk_50);
        #5 rst_i = 1'b1;
        #1;
        chk("arst_busy", 32'(bus.busy_o), 32'd0);
        chk("arst_done", 32'(bus.done_o), 32'd0);
        chk("arst_hi", bus.hi_o, 32'd0);
        chk("arst_lo", bus.lo_o, 32'd0);
        scb.delete();
        @(negedge clk_50);
        rst_i = 1'b0;
        nd    = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk_50);
            if (bus.done_o === 1'b1) nd++;
        end
        chk("no_done", 32'(nd), 32'd0);

        launch(2'b00, 32'd6, 32'd7, 1'b0);
        wait_done(1'b0);
        idle_chk();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
